mem_stage: RTL and testbench

//  MEM pipeline stage: consumes EX/MEM register outputs, performs loads/stores over a
//  req/ack data bus, and registers the result into the MEM/WB interface for writeback.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_lane_fmt.sv | 70 +++++++
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load/store op codes, FSM state type
// and decode helpers used by the stage and its lane formatter.
package mem_stage_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic RstEnable_n = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Halfwords need an even address, words need a 4-byte boundary.
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
    logic half_op;
    logic word_op;
    half_op = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    word_op = (op == EXE_LW_OP) || (op == EXE_SW_OP);
    return (half_op && a[0]) || (word_op && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane formatter: store lane enables/replication and
// load byte/half extraction with sign or zero extension.
module mem_lane_fmt
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_lo)
      2'd0:    rd_byte = rdata[31:24];
      2'd1:    rd_byte = rdata[23:16];
      2'd2:    rd_byte = rdata[15:8];
      default: rd_byte = rdata[7:0];
    endcase
    rd_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (aluop)
      EXE_LB_OP: begin
        sel       = 4'b1000 >> addr_lo;
        load_data = {{24{rd_byte[7]}}, rd_byte};
      end
      EXE_LBU_OP: begin
        sel       = 4'b1000 >> addr_lo;
        load_data = {24'h0, rd_byte};
      end
      EXE_LH_OP: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data = {{16{rd_half[15]}}, rd_half};
      end
      EXE_LHU_OP: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data = {16'h0, rd_half};
      end
      EXE_LW_OP: begin
        sel       = 4'b1111;
        load_data = rdata;
      end
      EXE_SB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        sel   = 4'b1111;
        wdata = reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack bus, stalls the pipe
// while an access is outstanding, aborts on timeout, registers MEM/WB results.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding; non-mem ops pass straight to MEM/WB
// ST_BUSY | bus_req held high, waiting for bus_ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic        stallreq,
  output logic        mem_err,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       fmt_sel;
  logic [31:0]      fmt_wdata, fmt_load;
  logic             op_load, op_mem, op_misal;
  logic             start, misal_hit, pass_thru, complete, abort, cnt_inc;

  assign op_load  = is_load(mem_aluop);
  assign op_mem   = op_load || is_store(mem_aluop);
  assign op_misal = is_misaligned(mem_aluop, mem_addr[1:0]);

  mem_lane_fmt u_lane_fmt (
    .aluop     (mem_aluop),
    .addr_lo   (mem_addr[1:0]),
    .reg2      (mem_reg2),
    .rdata     (bus_rdata),
    .sel       (fmt_sel),
    .wdata     (fmt_wdata),
    .load_data (fmt_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stallreq  = 1'b0;
    start     = 1'b0;
    misal_hit = 1'b0;
    pass_thru = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    cnt_inc   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!op_mem) begin
            pass_thru = 1'b1;
          end else if (op_misal) begin
            misal_hit = 1'b1;
          end else begin
            start    = 1'b1;
            stallreq = 1'b1;
            state_d  = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // ack on the terminal-count cycle still completes normally
          if (bus_ack) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else if (cnt_q == CNT_TC) begin
            abort   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stallreq = 1'b1;
            cnt_inc  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      cnt_q     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_sel   <= 4'b0000;
      bus_wdata <= 32'h0;
      mem_err   <= 1'b0;
      wb_wd     <= 5'd0;
      wb_wreg   <= 1'b0;
      wb_wdata  <= 32'h0;
    end else begin
      mem_err <= misal_hit | abort;
      if (flush) begin
        cnt_q    <= '0;
        bus_req  <= 1'b0;
        wb_wd    <= 5'd0;
        wb_wreg  <= 1'b0;
        wb_wdata <= 32'h0;
      end else begin
        if (start) begin
          cnt_q     <= '0;
          bus_req   <= 1'b1;
          bus_we    <= is_store(mem_aluop);
          bus_addr  <= {mem_addr[31:2], 2'b00};
          bus_sel   <= fmt_sel;
          bus_wdata <= fmt_wdata;
          wb_wreg   <= 1'b0;
        end
        if (misal_hit || abort) wb_wreg <= 1'b0;
        if (abort) bus_req <= 1'b0;
        if (pass_thru) begin
          wb_wd    <= mem_wd;
          wb_wreg  <= mem_wreg;
          wb_wdata <= mem_wdata;
        end
        if (complete) begin
          bus_req  <= 1'b0;
          wb_wd    <= mem_wd;
          wb_wreg  <= mem_wreg;
          wb_wdata <= op_load ? fmt_load : mem_wdata;
        end
        if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYCLES=4): pass-through, loads/stores,
// misalignment, timeout, flush and asynchronous reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  mem_aluop = 8'h00;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_reg2 = 32'h0;
  logic [4:0]  mem_wd = 5'd0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        bus_req, bus_we, stallreq, mem_err, wb_wreg;
  logic [31:0] bus_addr, bus_wdata, wb_wdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .stallreq(stallreq), .mem_err(mem_err),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_aluop = 8'h00;
    mem_wreg  = 1'b0;
  endtask

  // Full access with ack on the (busy_wait+1)-th BUSY cycle.
  task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata,
                        input int busy_wait, input logic [3:0] exp_sel,
                        input logic exp_we, input logic [31:0] exp_bwdata,
                        input logic [31:0] exp_wb);
    int stalls;
    stalls    = 0;
    mem_aluop = op;
    mem_addr  = addr;
    mem_reg2  = reg2;
    mem_wd    = 5'd7;
    mem_wreg  = 1'b1;
    mem_wdata = 32'h0000_0055;
    #1;
    if (stallreq) stalls++;
    tick();
    chk({tag, " bus_req"}, bus_req, 1'b1);
    chk({tag, " bus_we"}, bus_we, exp_we);
    chk({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
    chk({tag, " bus_sel"}, bus_sel, exp_sel);
    if (exp_we) chk({tag, " bus_wdata"}, bus_wdata, exp_bwdata);
    chk({tag, " bubble"}, wb_wreg, 1'b0);
    for (int i = 0; i < busy_wait; i++) begin
      if (stallreq) stalls++;
      tick();
      chk({tag, " hold_req"}, bus_req, 1'b1);
      chk({tag, " hold_sel"}, bus_sel, exp_sel);
    end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    #1;
    chk({tag, " ack_stall"}, stallreq, 1'b0);
    tick();
    bus_ack = 1'b0;
    nop();
    chk({tag, " stall_cycles"}, stalls, busy_wait + 1);
    chk({tag, " req_drop"}, bus_req, 1'b0);
    chk({tag, " wb_wd"}, wb_wd, 5'd7);
    chk({tag, " wb_wreg"}, wb_wreg, 1'b1);
    chk({tag, " wb_wdata"}, wb_wdata, exp_wb);
    chk({tag, " no_err"}, mem_err, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst bus_req", bus_req, 1'b0);
    chk("rst wb_wreg", wb_wreg, 1'b0);
    chk("rst wb_wdata", wb_wdata, 32'h0);
    chk("rst mem_err", mem_err, 1'b0);
    chk("rst bus_sel", bus_sel, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: non-memory op passes through with latency 1
    mem_aluop = 8'h21; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    #1;
    chk("nonmem stall", stallreq, 1'b0);
    tick();
    chk("nonmem wb_wd", wb_wd, 5'd5);
    chk("nonmem wb_wreg", wb_wreg, 1'b1);
    chk("nonmem wb_wdata", wb_wdata, 32'h1234);
    nop();

    // 2/3: loads and stores, lane selection and extension
    access("lb",  EXE_LB_OP,  32'h103, 32'h0, 32'h0000_00F0, 3, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FFF0);
    access("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 3, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0);
    access("sh",  EXE_SH_OP,  32'h102, 32'hABCD, 32'h0, 0, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h55);
    access("sb",  EXE_SB_OP,  32'h101, 32'h5A, 32'h0, 1, 4'b0100, 1'b1, 32'h5A5A_5A5A, 32'h55);
    access("lh",  EXE_LH_OP,  32'h100, 32'h0, 32'h8001_7777, 0, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001);
    access("lhu", EXE_LHU_OP, 32'h102, 32'h0, 32'h1234_8001, 1, 4'b0011, 1'b0, 32'h0, 32'h0000_8001);
    access("lw",  EXE_LW_OP,  32'h104, 32'h0, 32'hCAFE_F00D, 2, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    access("sw",  EXE_SW_OP,  32'h108, 32'h1357_9BDF, 32'h0, 0, 4'b1111, 1'b1, 32'h1357_9BDF, 32'h55);

    // 4: misaligned word load
    mem_aluop = EXE_LW_OP; mem_addr = 32'h101; mem_wreg = 1'b1;
    #1;
    chk("misal stall", stallreq, 1'b0);
    tick();
    nop();
    chk("misal bus_req", bus_req, 1'b0);
    chk("misal mem_err", mem_err, 1'b1);
    chk("misal wb_wreg", wb_wreg, 1'b0);
    tick();
    chk("misal err_pulse", mem_err, 1'b0);

    // 5: timeout after 4 BUSY cycles without ack
    mem_aluop = EXE_LW_OP; mem_addr = 32'h200; mem_wreg = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("tmo req", bus_req, 1'b1);
      chk("tmo stall", stallreq, 1'b1);
      tick();
    end
    chk("tmo req_last", bus_req, 1'b1);
    chk("tmo stall_release", stallreq, 1'b0);
    tick();
    nop();
    chk("tmo req_drop", bus_req, 1'b0);
    chk("tmo mem_err", mem_err, 1'b1);
    chk("tmo wb_wreg", wb_wreg, 1'b0);
    tick();
    chk("tmo err_pulse", mem_err, 1'b0);
    access("ack_tc", EXE_LW_OP, 32'h204, 32'h0, 32'h0BAD_BEEF, 3, 4'b1111, 1'b0, 32'h0, 32'h0BAD_BEEF);

    // 6: flush overrides a same-cycle ack
    mem_aluop = EXE_LW_OP; mem_addr = 32'h300; mem_wreg = 1'b1;
    tick();
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    chk("flush stall", stallreq, 1'b0);
    tick();
    flush = 1'b0; bus_ack = 1'b0;
    nop();
    chk("flush req", bus_req, 1'b0);
    chk("flush wb_wreg", wb_wreg, 1'b0);
    chk("flush wb_wdata", wb_wdata, 32'h0);
    chk("flush err", mem_err, 1'b0);
    #1;
    chk("flush idle", stallreq, 1'b0);

    // async reset mid-BUSY
    tick();
    mem_aluop = EXE_LW_OP; mem_addr = 32'h304; mem_wreg = 1'b1;
    tick();
    chk("arst pre_req", bus_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst req_drop", bus_req, 1'b0);
    chk("arst bus_sel", bus_sel, 4'b0000);
    nop();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst idle", stallreq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
